hazard_sequencer: RTL and testbench

Pipeline sequencing unit for the 6-stage MIPS core (IF, ID, RR, EX, MEM, WB). It runs beside the opcode decoder.

- **Inputs:** the ID-stage opcode and source registers, plus the EX-stage branch outcome.
- **Load-use hazards:** it tracks recently issued `lw` destinations in a two-slot scoreboard and inserts the required bubbles.
- **Control hazards:** it redirects the PC and flushes younger stages on `j` and taken `bne`.
- **Gating and statistics:** it gates pipeline start after reset and keeps saturating stall/flush statistics counters.

---
 rtl/hazard_sequencer_if.sv | 34 +++
 rtl/hazard_sequencer.sv | 125 ++++++++++++
 tb/tb_hazard_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_sequencer_if.sv
// Sequencer bus: ID-stage instruction fields, EX branch outcome, and the
// pipeline control and statistics returned by the sequencer.
interface hazard_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             id_valid;
  logic [5:0]       id_opcode;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             ex_branch_taken;
  logic             running;
  logic             pc_write;
  logic             ifid_write;
  logic             bubble_id;
  logic             flush_if;
  logic             flush_id;
  logic             flush_rr;
  logic [1:0]       pc_src;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output start, id_valid, id_opcode, id_rs, id_rt, ex_branch_taken,
    input  running, pc_write, ifid_write, bubble_id,
           flush_if, flush_id, flush_rr, pc_src, stall_cnt, flush_cnt
  );

  modport slave (
    input  start, id_valid, id_opcode, id_rs, id_rt, ex_branch_taken,
    output running, pc_write, ifid_write, bubble_id,
           flush_if, flush_id, flush_rr, pc_src, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline sequencer for the 6-stage MIPS core: start gating, load-use
// stalls from a two-slot load scoreboard, jump/branch redirect and flush,
// and saturating stall/flush statistics.
module hazard_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  hazard_sequencer_if.slave bus
);
  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 6;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
  localparam logic [OP_W-1:0] OP_XORI = 6'b001110;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic             s1_v, s2_v;
  logic [REG_W-1:0] s1_r, s2_r;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic use_rs, use_rt, hit_rs, hit_rt;
  logic run, branch, stall, jump, issue_lw;

  // Which source fields the ID opcode actually reads.
  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    case (bus.id_opcode)
      OP_R, OP_SW, OP_BNE: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_LW, OP_XORI: use_rs = 1'b1;
      default: ;
    endcase
  end

  // Register 0 is hard-wired, so it never creates a dependency.
  assign hit_rs = (bus.id_rs != '0) &&
                  ((s1_v && (s1_r == bus.id_rs)) || (s2_v && (s2_r == bus.id_rs)));
  assign hit_rt = (bus.id_rt != '0) &&
                  ((s1_v && (s1_r == bus.id_rt)) || (s2_v && (s2_r == bus.id_rt)));

  assign run      = (state == RUN);
  assign branch   = run && bus.ex_branch_taken;
  assign stall    = run && bus.id_valid && !branch &&
                    ((use_rs && hit_rs) || (use_rt && hit_rt));
  assign jump     = run && bus.id_valid && !branch && (bus.id_opcode == OP_J);
  assign issue_lw = run && bus.id_valid && !branch && !stall &&
                    (bus.id_opcode == OP_LW) && (bus.id_rt != '0);

  // Pipeline control; branch redirect outranks stall and jump.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.ifid_write = 1'b0;
    bus.bubble_id  = 1'b1;
    bus.flush_if   = 1'b0;
    bus.flush_id   = 1'b0;
    bus.flush_rr   = 1'b0;
    bus.pc_src     = 2'b00;
    if (run) begin
      bus.pc_write   = 1'b1;
      bus.ifid_write = 1'b1;
      bus.bubble_id  = 1'b0;
      if (branch) begin
        bus.pc_src   = 2'b10;
        bus.flush_if = 1'b1;
        bus.flush_id = 1'b1;
        bus.flush_rr = 1'b1;
      end else if (stall) begin
        bus.pc_write   = 1'b0;
        bus.ifid_write = 1'b0;
        bus.bubble_id  = 1'b1;
      end else if (jump) begin
        bus.pc_src   = 2'b01;
        bus.flush_if = 1'b1;
      end
    end
  end

  assign bus.running   = run;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;

  // FSM, scoreboard aging and saturating statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      s1_v    <= 1'b0;
      s1_r    <= '0;
      s2_v    <= 1'b0;
      s2_r    <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        state <= RUN;
      end
      if (!run || branch) begin
        s1_v <= 1'b0;
        s1_r <= '0;
        s2_v <= 1'b0;
        s2_r <= '0;
      end else begin
        s2_v <= s1_v;
        s2_r <= s1_r;
        s1_v <= issue_lw;
        s1_r <= issue_lw ? bus.id_rt : '0;
      end
      if (stall && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (branch && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: a 16-bit-counter instance for the
// main scenarios and a 2-bit-counter instance for saturation.
module tb_hazard_sequencer;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  hazard_sequencer_if #(.CNT_W(16)) hif ();
  hazard_sequencer_if #(.CNT_W(2))  sif ();

  hazard_sequencer #(.CNT_W(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(hif));
  hazard_sequencer #(.CNT_W(2))  u_sat (.clk(clk), .rst_n(rst_n), .bus(sif));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic br);
    hif.id_valid        = v;
    hif.id_opcode       = op;
    hif.id_rs           = rs;
    hif.id_rt           = rt;
    hif.ex_branch_taken = br;
    #1;
  endtask

  task automatic set_sid(input logic v, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic br);
    sif.id_valid        = v;
    sif.id_opcode       = op;
    sif.id_rs           = rs;
    sif.id_rt           = rt;
    sif.ex_branch_taken = br;
    #1;
  endtask

  task automatic chk_norm(input string tag);
    chk({tag, ".pc_write"},   32'(hif.pc_write),   32'd1);
    chk({tag, ".ifid_write"}, 32'(hif.ifid_write), 32'd1);
    chk({tag, ".bubble_id"},  32'(hif.bubble_id),  32'd0);
    chk({tag, ".pc_src"},     32'(hif.pc_src),     32'd0);
    chk({tag, ".flush_if"},   32'(hif.flush_if),   32'd0);
  endtask

  task automatic chk_stall(input string tag);
    chk({tag, ".pc_write"},   32'(hif.pc_write),   32'd0);
    chk({tag, ".ifid_write"}, 32'(hif.ifid_write), 32'd0);
    chk({tag, ".bubble_id"},  32'(hif.bubble_id),  32'd1);
    chk({tag, ".flush_id"},   32'(hif.flush_id),   32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".running"},  32'(hif.running),  32'd0);
    chk({tag, ".pc_write"}, 32'(hif.pc_write), 32'd0);
    chk({tag, ".bubble"},   32'(hif.bubble_id), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    hif.start = 1'b0;
    sif.start = 1'b0;
    set_id(1'b0, OP_R, 5'd0, 5'd0, 1'b0);
    set_sid(1'b0, OP_R, 5'd0, 5'd0, 1'b0);

    // Reset held two cycles.
    cyc();
    cyc();
    chk_idle("rst");
    chk("rst.stall_cnt", 32'(hif.stall_cnt), 32'd0);
    chk("rst.flush_cnt", 32'(hif.flush_cnt), 32'd0);

    // Released but no start: stays gated.
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_idle("gate");
    end

    hif.start = 1'b1;
    cyc();
    hif.start = 1'b0;
    #1;
    chk("start.running", 32'(hif.running), 32'd1);
    chk_norm("start");

    // Back-to-back load-use: two stall cycles.
    set_id(1'b1, OP_LW, 5'd1, 5'd5, 1'b0);
    chk_norm("b2b.lw");
    cyc();
    set_id(1'b1, OP_R, 5'd5, 5'd2, 1'b0);
    chk_stall("b2b.st1");
    cyc();
    chk_stall("b2b.st2");
    cyc();
    chk_norm("b2b.go");
    chk("b2b.stall_cnt", 32'(hif.stall_cnt), 32'd2);
    cyc();

    // One instruction between: one stall; xori ignores its rt field.
    set_id(1'b1, OP_LW, 5'd0, 5'd7, 1'b0);
    cyc();
    set_id(1'b1, OP_XORI, 5'd3, 5'd7, 1'b0);
    chk_norm("gap.xori");
    cyc();
    set_id(1'b1, OP_SW, 5'd4, 5'd7, 1'b0);
    chk_stall("gap.sw");
    cyc();
    chk_norm("gap.go");
    chk("gap.stall_cnt", 32'(hif.stall_cnt), 32'd3);
    cyc();

    // Load to r0 never creates a hazard.
    set_id(1'b1, OP_LW, 5'd2, 5'd0, 1'b0);
    cyc();
    set_id(1'b1, OP_R, 5'd0, 5'd0, 1'b0);
    chk_norm("r0");
    cyc();

    // Jump.
    set_id(1'b1, OP_J, 5'd0, 5'd0, 1'b0);
    chk("j.pc_src",   32'(hif.pc_src),     32'd1);
    chk("j.flush_if", 32'(hif.flush_if),   32'd1);
    chk("j.flush_id", 32'(hif.flush_id),   32'd0);
    chk("j.pc_write", 32'(hif.pc_write),   32'd1);
    chk("j.ifid",     32'(hif.ifid_write), 32'd1);
    chk("j.bubble",   32'(hif.bubble_id),  32'd0);
    cyc();
    set_id(1'b0, OP_J, 5'd0, 5'd0, 1'b0);
    chk_norm("j.after");
    chk("j.flush_cnt", 32'(hif.flush_cnt), 32'd0);

    // Taken branch beats a pending load-use stall and clears the slots.
    set_id(1'b1, OP_LW, 5'd1, 5'd9, 1'b0);
    cyc();
    set_id(1'b1, OP_R, 5'd9, 5'd1, 1'b1);
    chk("br.pc_src",   32'(hif.pc_src),    32'd2);
    chk("br.flush_if", 32'(hif.flush_if),  32'd1);
    chk("br.flush_id", 32'(hif.flush_id),  32'd1);
    chk("br.flush_rr", 32'(hif.flush_rr),  32'd1);
    chk("br.pc_write", 32'(hif.pc_write),  32'd1);
    chk("br.bubble",   32'(hif.bubble_id), 32'd0);
    cyc();
    set_id(1'b1, OP_R, 5'd9, 5'd1, 1'b0);
    chk_norm("br.after");
    chk("br.flush_cnt", 32'(hif.flush_cnt), 32'd1);
    chk("br.stall_cnt", 32'(hif.stall_cnt), 32'd3);
    cyc();

    // id_valid=0 records nothing but slots keep aging.
    set_id(1'b1, OP_LW, 5'd1, 5'd6, 1'b0);
    cyc();
    set_id(1'b0, OP_R, 5'd6, 5'd6, 1'b0);
    chk_norm("nv.idle");
    cyc();
    set_id(1'b1, OP_R, 5'd6, 5'd0, 1'b0);
    chk_stall("nv.slot2");
    cyc();
    chk_norm("nv.go");
    chk("nv.stall_cnt", 32'(hif.stall_cnt), 32'd4);
    cyc();

    // Reset in the middle of a stall.
    set_id(1'b1, OP_LW, 5'd1, 5'd6, 1'b0);
    cyc();
    set_id(1'b1, OP_R, 5'd6, 5'd0, 1'b0);
    chk_stall("mid.stall");
    rst_n = 1'b0;
    cyc();
    chk_idle("mid.rst");
    chk("mid.stall_cnt", 32'(hif.stall_cnt), 32'd0);
    chk("mid.flush_cnt", 32'(hif.flush_cnt), 32'd0);

    // Start during reset is lost.
    hif.start = 1'b1;
    cyc();
    chk("rstwin.running", 32'(hif.running), 32'd0);
    rst_n = 1'b1;
    cyc();
    hif.start = 1'b0;
    #1;
    chk("restart.running", 32'(hif.running), 32'd1);
    chk_norm("restart.noslot");

    // Saturation on a 2-bit-counter instance.
    sif.start = 1'b1;
    cyc();
    sif.start = 1'b0;
    set_sid(1'b1, OP_LW, 5'd1, 5'd5, 1'b0);
    cyc();
    set_sid(1'b1, OP_R, 5'd5, 5'd0, 1'b0);
    cyc();
    cyc();
    chk("sat.two", 32'(sif.stall_cnt), 32'd2);
    cyc();
    set_sid(1'b1, OP_LW, 5'd1, 5'd5, 1'b0);
    cyc();
    set_sid(1'b1, OP_R, 5'd5, 5'd0, 1'b0);
    chk("sat.stalling", 32'(sif.pc_write), 32'd0);
    cyc();
    chk("sat.max", 32'(sif.stall_cnt), 32'd3);
    chk("sat.still", 32'(sif.pc_write), 32'd0);
    cyc();
    chk("sat.hold", 32'(sif.stall_cnt), 32'd3);
    set_sid(1'b0, OP_R, 5'd0, 5'd0, 1'b1);
    for (int i = 0; i < 4; i++) cyc();
    chk("sat.flush_hold", 32'(sif.flush_cnt), 32'd3);
    chk("sat.stall_keep", 32'(sif.stall_cnt), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
